// File: rtl/mul_ctrl.sv
// mul_ctrl: sequential 32x32 multiplier (MUL/MULH/MULHSU/MULHU) built as a
// radix-2 shift-add engine behind a valid/ready request/response handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present on op/in1/in2
//   in_ready   request accepted on this edge if in_valid (IDLE and no flush)
//   op         0 MUL (low 32), 1 MULH (s*s), 2 MULHSU (s*u), 3 MULHU (u*u)
//   in1, in2   multiplicand (rs1) and multiplier (rs2)
//   flush      synchronous abort; forces IDLE on the next edge, result lost
//   out_valid  result on out is valid (DONE state)
//   out_ready  consumer takes the result
//   out        selected half of the 64-bit product
//   busy       state is not IDLE
//
// Build option: define MUL_EARLY_OUT_EN to leave CALC as soon as the
// remaining multiplier bits are all zero. Results are the same either way;
// only latency changes.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  logic [1:0]  state;
  logic [1:0]  op_r;
  logic        sign_r;
  logic [63:0] mcand;   // multiplicand magnitude, shifted left each step
  logic [31:0] mplier;  // multiplier magnitude, shifted right each step
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [63:0] result;

  logic        neg1;
  logic        neg2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        sign_in;
  logic [63:0] acc_step;
  logic        last_step;

  // Operands are reduced to unsigned magnitudes; the sign is reapplied to the
  // full 64-bit product. 0x80000000 negates to itself, which is the correct
  // unsigned magnitude.
  always_comb begin
    neg1     = in1[31] && ((op == OP_MULH) || (op == OP_MULHSU));
    neg2     = in2[31] && (op == OP_MULH);
    mag1     = neg1 ? (~in1 + 32'd1) : in1;
    mag2     = neg2 ? (~in2 + 32'd1) : in2;
    sign_in  = neg1 ^ neg2;
    acc_step = mplier[0] ? (acc + mcand) : acc;
`ifdef MUL_EARLY_OUT_EN
    // Once the bits still to be shifted in are zero, acc_step is final.
    last_step = (cnt == 5'd31) || (mplier[31:1] == '0);
`else
    last_step = (cnt == 5'd31);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= '0;
      sign_r <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r   <= op;
            sign_r <= sign_in;
            mcand  <= {32'd0, mag1};
            mplier <= mag2;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_step) begin
            result <= sign_r ? (~acc_step + 64'd1) : acc_step;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out       = (op_r == OP_MUL) ? result[31:0] : result[63:32];

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: directed corner cases plus randomized traffic, checked
// by a queue-based scoreboard against an arithmetic product model.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = '0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        busy;

  mul_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 0;
  logic [31:0] held;
  bit   rand_ready = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference product: exact integer product of the operands interpreted
  // according to op, truncated to 64 bits.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int steps;
    m = (o == 2'd1 && b[31]) ? -b : b;
    steps = 32;
`ifdef MUL_EARLY_OUT_EN
    steps = 1;
    for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
`endif
    return steps + 1;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      seen = 0;
    end else begin
      chk("in_ready_vs_busy", in_ready, !busy && !flush);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("result", out, e.val);
            held = out;
            seen = 1;
          end else begin
            chk("hold_stable", out, held);
          end
          if (out_ready && !flush) begin
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
      if (flush) begin
        exp_q.delete();
        seen = 0;
      end
      if (in_valid && in_ready) begin
        e.val = model(op, in1, in2);
        e.acc = cyc;
        e.lat = exp_lat(op, in2);
        exp_q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(posedge clk); #1;
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 300, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed products.
    out_ready = 1'b1;
    issue(2'd0, 32'd7, 32'hFFFF_FFFD);          drain();
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);  drain();
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  drain();
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  drain();
    issue(2'd3, 32'd5, 32'd1);                  drain();
    issue(2'd0, 32'd5, 32'd1);                  drain();
    issue(2'd1, 32'hFFFF_FFF9, 32'd0);          drain();

    // Back-pressure in DONE with a competing request.
    out_ready = 1'b0;
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    op = 2'd0; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid_high", out_valid, 1'b1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // Flush mid-CALC.
    issue(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    repeat (40) begin
      @(negedge clk);
      chk("flush_no_valid", out_valid, 1'b0);
    end

    // Reset mid-CALC.
    issue(2'd3, 32'hFFFF_0000, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 32'h0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 1'b0);
    end

    // Randomized traffic with random consumer back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_ready = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present on op/in1/in2.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  2  0 MUL (low 32), 1 MULH (s*s high), 2 MULHSU (s*u high), 3 MULHU (u*u high).
REQ-007 in1, in2  input  32 each  multiplicand (rs1) and multiplier (rs2).
REQ-008 flush  input  1  synchronous abort of any in-flight operation.
REQ-009 out_valid  output  1  result on out is valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out  output  32  selected result half.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 in_ready SHALL equal (state==IDLE && !flush); a request is accepted on the edge where in_valid && in_ready.
REQ-015 On accept, the block SHALL register op, a sign flag and magnitudes, then enter CALC with a 5-bit iteration counter at 0.
REQ-016 Magnitudes: in1 is negated when in1[31]=1 and op is MULH or MULHSU; in2 is negated when in2[31]=1 and op is MULH. 0x80000000 stays 0x80000000 as an unsigned magnitude.
REQ-017 Sign flag: in1[31]^in2[31] for MULH, in1[31] for MULHSU, 0 for MUL and MULHU.
REQ-018 Each CALC cycle SHALL perform one radix-2 shift-add step into a 64-bit unsigned accumulator and increment the counter.
REQ-019 After the step with counter==31, the FSM SHALL go to DONE. On that edge the result register SHALL be loaded with the two's-complement negation of the accumulator if the sign flag is set, else the accumulator.
REQ-020 out SHALL be result[31:0] for MUL and result[63:32] otherwise.
REQ-021 out_valid SHALL be 1 only in DONE.
REQ-022 Latency: with acceptance at edge T, out_valid SHALL first be high in the cycle after edge T+32. That is 32 CALC cycles, and out_valid asserts 33 cycles after the accept cycle.
REQ-023 In DONE, out and out_valid SHALL hold stable until out_ready=1. On that edge the FSM returns to IDLE.
REQ-024 in_valid during CALC or DONE SHALL be ignored, since in_ready is 0. The earliest next accept is the cycle after the DONE handshake.
REQ-025 flush=1 SHALL force IDLE on the next edge from any state and discard the result. It takes priority over accept and over the out_ready handshake in the same cycle.
REQ-026 op values are exhaustive; no illegal-op case exists.

Reset
REQ-027 While rst_n=0, the block SHALL immediately set state=IDLE, counter=0, accumulator=0, result=0 and op=0. In that condition out=0, out_valid=0, busy=0, and in_ready=1 (flush permitting).
REQ-028 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation with no out_valid afterwards.

Configuration
REQ-029 Macro MUL_EARLY_OUT_EN SHALL control early termination of CALC.
REQ-030 When MUL_EARLY_OUT_EN is defined, CALC SHALL also go to DONE after any step where the remaining (shifted) multiplier bits are all zero. Latency then ranges from 2 cycles (in2 magnitude 0 or 1) to 33 cycles.
REQ-031 When MUL_EARLY_OUT_EN is undefined, CALC SHALL always last exactly 32 cycles.
REQ-032 Results SHALL be identical with and without MUL_EARLY_OUT_EN.

Verification
REQ-033 MUL, in1=7, in2=0xFFFFFFFD -> out=0xFFFFFFEB, with out_valid 33 cycles after accept (macro off).
REQ-034 MULH, in1=in2=0x80000000 -> out=0x40000000. MULHU, in1=in2=0xFFFFFFFF -> out=0xFFFFFFFE.
REQ-035 MULHSU, in1=0xFFFFFFFF, in2=0xFFFFFFFF -> out=0xFFFFFFFF (product 0xFFFFFFFF00000001).
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out stable, in_ready=0 throughout. Then out_ready=1 -> IDLE next edge, and the new request is accepted the following cycle.
REQ-037 Flush at CALC cycle 10 -> IDLE next edge, no out_valid, busy=0. Separately, rst_n=0 mid-CALC -> out=0, out_valid=0 immediately.
REQ-038 With MUL_EARLY_OUT_EN defined, MULHU in1=5, in2=1 -> out=0, out_valid 2 cycles after accept. MUL in1=5, in2=1 -> out=5.
